// File: rtl/flasher_pkg.sv
// Shared constants and phase encoding for the LED flasher and its monitor.
// Also usable by the flasher itself and by benches.
package flasher_pkg;

  localparam int LED_W = 16;
  localparam int CNT_W = $clog2(LED_W + 1);

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_RISING  = 2'd1,
    PH_FALLING = 2'd2
  } phase_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

endpackage

// File: rtl/therm_decode.sv
// Thermometer-code check and lamp count for the flasher LED vector.
// Valid only when the vector is (1<<k)-1; count is then k.
import flasher_pkg::*;

module therm_decode #(
  parameter int W  = flasher_pkg::LED_W,
  parameter int CW = flasher_pkg::CNT_W
) (
  input  logic [W-1:0]  vec,
  output logic          valid,
  output logic [CW-1:0] count
);

  // A run of low ones has no bit in common with itself plus one.
  assign valid = ((vec & (vec + W'(1))) == '0);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/flasher_monitor.sv
// Watches the flasher LED vector, tracks rise/fall phase and turns,
// and flags malformed codes and multi-lamp jumps.
import flasher_pkg::*;

module flasher_monitor #(
  parameter int LED_W = flasher_pkg::LED_W,
  parameter int CNT_W = flasher_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [LED_W-1:0] led_in,
  output logic [CNT_W-1:0] lit_count,
  output logic [1:0]       phase,
  output logic             peak_valid,
  output logic             trough_valid,
  output logic [CNT_W-1:0] turn_level,
  output logic [3:0]       turn_cnt,
  output logic             seq_done,
  output logic             code_err,
  output logic             step_err
);

  logic             valid;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] prev_count;
  logic [CNT_W-1:0] diff;
  logic             up;
  logic             down;
  logic             zero;
  logic             big;
  phase_e           state;

  therm_decode #(
    .W  (LED_W),
    .CW (CNT_W)
  ) u_dec (
    .vec   (led_in),
    .valid (valid),
    .count (k)
  );

  assign up   = (k > prev_count);
  assign down = (k < prev_count);
  assign zero = (k == '0);
  assign diff = up ? (k - prev_count) : (prev_count - k);
  assign big  = (diff > CNT_W'(1));

  assign lit_count = prev_count;
  assign phase     = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= PH_IDLE;
      prev_count   <= '0;
      turn_level   <= '0;
      turn_cnt     <= '0;
      peak_valid   <= 1'b0;
      trough_valid <= 1'b0;
      seq_done     <= 1'b0;
      code_err     <= 1'b0;
      step_err     <= 1'b0;
    end else begin
      peak_valid   <= 1'b0;
      trough_valid <= 1'b0;
      seq_done     <= 1'b0;
      code_err     <= 1'b0;
      step_err     <= 1'b0;
      if (!valid) begin
        code_err <= 1'b1;
      end else begin
        step_err   <= big;
        prev_count <= k;
        unique case (state)
          PH_IDLE: begin
            if (up) begin
              state    <= PH_RISING;
              turn_cnt <= '0;
            end
          end
          PH_RISING: begin
            if (down) begin
              peak_valid <= 1'b1;
              turn_level <= prev_count;
              turn_cnt   <= sat_inc4(turn_cnt);
              seq_done   <= zero;
              state      <= zero ? PH_IDLE : PH_FALLING;
            end
          end
          PH_FALLING: begin
            if (up) begin
              trough_valid <= 1'b1;
              turn_level   <= prev_count;
              turn_cnt     <= sat_inc4(turn_cnt);
              state        <= PH_RISING;
            end else if (zero) begin
              seq_done <= 1'b1;
              state    <= PH_IDLE;
            end
          end
          default: state <= PH_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flasher_monitor.sv
// Bench for flasher_monitor: directed scenarios plus random walk,
// every cycle compared against a direction-based reference model.
module tb_flasher_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] led_in = '0;
  logic [4:0]  lit_count;
  logic [1:0]  phase;
  logic        peak_valid;
  logic        trough_valid;
  logic [4:0]  turn_level;
  logic [3:0]  turn_cnt;
  logic        seq_done;
  logic        code_err;
  logic        step_err;

  flasher_monitor dut (
    .clock        (clock),
    .reset        (reset),
    .led_in       (led_in),
    .lit_count    (lit_count),
    .phase        (phase),
    .peak_valid   (peak_valid),
    .trough_valid (trough_valid),
    .turn_level   (turn_level),
    .turn_cnt     (turn_cnt),
    .seq_done     (seq_done),
    .code_err     (code_err),
    .step_err     (step_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // model: level, direction of travel (0 none, 1 up, 2 down), turns
  int m_lvl, m_dir, m_turns, m_tlvl;
  int m_peak, m_trough, m_seq, m_cerr, m_serr;

  int n_peak, n_trough, n_seq, n_cerr, n_serr;
  int lvls[$];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] therm(input int k);
    return 16'((32'h1 << k) - 1);
  endfunction

  task automatic model(input logic [15:0] v, input bit rst);
    int k;
    m_peak = 0; m_trough = 0; m_seq = 0; m_cerr = 0; m_serr = 0;
    if (rst) begin
      m_lvl = 0; m_dir = 0; m_turns = 0; m_tlvl = 0;
      return;
    end
    k = -1;
    for (int j = 0; j <= 16; j++)
      if (int'(v) == (1 << j) - 1) k = j;
    if (k < 0) begin
      m_cerr = 1;
      return;
    end
    m_serr = (k - m_lvl > 1 || m_lvl - k > 1) ? 1 : 0;
    if (k > m_lvl) begin
      if (m_dir == 0) begin
        m_turns = 0;
      end else if (m_dir == 2) begin
        m_trough = 1; m_tlvl = m_lvl;
        m_turns = (m_turns < 15) ? m_turns + 1 : 15;
      end
      m_dir = 1;
    end else if (k < m_lvl) begin
      if (m_dir == 1) begin
        m_peak = 1; m_tlvl = m_lvl;
        m_turns = (m_turns < 15) ? m_turns + 1 : 15;
      end
      m_dir = 2;
      if (k == 0) begin
        m_seq = 1; m_dir = 0;
      end
    end
    m_lvl = k;
  endtask

  task automatic apply(input logic [15:0] v, input bit rst);
    @(negedge clock);
    led_in = v;
    reset  = rst;
    @(posedge clock);
    #1;
    model(v, rst);
    check("lit_count", int'(lit_count), m_lvl);
    check("phase", int'(phase), m_dir);
    check("peak_valid", int'(peak_valid), m_peak);
    check("trough_valid", int'(trough_valid), m_trough);
    check("turn_level", int'(turn_level), m_tlvl);
    check("turn_cnt", int'(turn_cnt), m_turns);
    check("seq_done", int'(seq_done), m_seq);
    check("code_err", int'(code_err), m_cerr);
    check("step_err", int'(step_err), m_serr);
    n_peak   += int'(peak_valid);
    n_trough += int'(trough_valid);
    n_seq    += int'(seq_done);
    n_cerr   += int'(code_err);
    n_serr   += int'(step_err);
    if (peak_valid || trough_valid) lvls.push_back(int'(turn_level));
  endtask

  task automatic clr();
    n_peak = 0; n_trough = 0; n_seq = 0; n_cerr = 0; n_serr = 0;
    lvls.delete();
  endtask

  task automatic go_to(input int tgt);
    int c;
    c = m_lvl;
    while (c != tgt) begin
      c += (tgt > c) ? 1 : -1;
      apply(therm(c), 1'b0);
    end
  endtask

  initial begin
    int r, k;
    logic [15:0] v;

    apply(16'hFFFF, 1'b1);
    apply(16'h0000, 1'b1);

    // ramp 0..6 and back
    clr();
    go_to(6);
    go_to(0);
    check("ramp_peaks", n_peak, 1);
    check("ramp_level", lvls.size() > 0 ? lvls[0] : -1, 6);
    check("ramp_seq", n_seq, 1);
    check("ramp_turns", int'(turn_cnt), 1);
    check("ramp_errs", n_cerr + n_serr, 0);

    // kickback
    clr();
    go_to(10);
    go_to(5);
    go_to(16);
    go_to(0);
    check("kick_turns", int'(turn_cnt), 3);
    check("kick_n", lvls.size(), 3);
    if (lvls.size() == 3) begin
      check("kick_l0", lvls[0], 10);
      check("kick_l1", lvls[1], 5);
      check("kick_l2", lvls[2], 16);
    end
    check("kick_seq", n_seq, 1);

    // bad code mid-ramp
    go_to(2);
    apply(16'h0005, 1'b0);
    check("bad_cerr", int'(code_err), 1);
    check("bad_lit", int'(lit_count), 2);
    check("bad_phase", int'(phase), 1);
    apply(therm(2), 1'b0);
    check("bad_clear", int'(code_err), 0);

    // jump 3 -> 8
    go_to(3);
    apply(16'h00FF, 1'b0);
    check("jmp_serr", int'(step_err), 1);
    check("jmp_lit", int'(lit_count), 8);
    check("jmp_phase", int'(phase), 1);
    check("jmp_turn", int'(peak_valid | trough_valid), 0);

    // reset while falling at 9
    go_to(10);
    go_to(9);
    check("rst_pre", int'(phase), 2);
    apply(therm(9), 1'b1);
    apply(16'h0000, 1'b0);
    check("rst_phase", int'(phase), 0);
    check("rst_lit", int'(lit_count), 0);
    check("rst_seq", int'(seq_done), 0);
    check("rst_tl", int'(turn_level), 0);
    apply(therm(6), 1'b0);
    check("rst_rise", int'(phase), 1);
    check("rst_serr", int'(step_err), 1);

    // 20 turns
    go_to(0);
    go_to(3);
    for (int t = 0; t < 20; t++) go_to((t % 2 == 0) ? 2 : 3);
    check("sat_turns", int'(turn_cnt), 15);

    // random walk
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        apply(16'($urandom), 1'b1);
      end else if (r < 10) begin
        v = 16'($urandom);
        apply(v, 1'b0);
      end else begin
        if (r < 18) k = $urandom_range(0, 16);
        else k = m_lvl + $urandom_range(0, 4) - 2;
        if (k < 0) k = 0;
        if (k > 16) k = 16;
        apply(therm(k), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
